rambus_wb_arbiter: RTL and testbench

- Parametrised N-client arbiter for the shared OpenRAM wishbone bus (the rambus port of a wrapped project).
- Lets several internal masters, such as a CPU-side wishbone bridge and a project datapath, share one rambus master port.
- Uses round-robin grant, registered bus outputs, an ack timeout and active gating.
- Sits between project logic and the wrapper's rambus_wb_* ports.

---
 rtl/rambus_wb_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_rambus_wb_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_wb_arbiter.sv
// Round-robin N-client arbiter for the shared OpenRAM wishbone (rambus) port.
// Registered bus outputs, per-transaction ack timeout and active gating of new grants.
module rambus_wb_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          active,
    input  logic [N_CLIENTS-1:0]          cli_cyc_i,
    input  logic [N_CLIENTS-1:0]          cli_stb_i,
    input  logic [N_CLIENTS-1:0]          cli_we_i,
    input  logic [N_CLIENTS*DATA_W/8-1:0] cli_sel_i,
    input  logic [N_CLIENTS*ADDR_W-1:0]   cli_adr_i,
    input  logic [N_CLIENTS*DATA_W-1:0]   cli_dat_i,
    output logic [N_CLIENTS-1:0]          cli_ack_o,
    output logic [N_CLIENTS-1:0]          cli_err_o,
    output logic [DATA_W-1:0]             cli_dat_o,
    output logic                          rambus_wb_clk_o,
    output logic                          rambus_wb_rst_o,
    output logic                          rambus_wb_cyc_o,
    output logic                          rambus_wb_stb_o,
    output logic                          rambus_wb_we_o,
    output logic [DATA_W/8-1:0]           rambus_wb_sel_o,
    output logic [ADDR_W-1:0]             rambus_wb_adr_o,
    output logic [DATA_W-1:0]             rambus_wb_dat_o,
    input  logic                          rambus_wb_ack_i,
    input  logic [DATA_W-1:0]             rambus_wb_dat_i,
    output logic [N_CLIENTS-1:0]          grant_o,
    output logic [7:0]                    timeout_cnt_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int TMR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [ADDR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]    wdat_q, wdat_d;
    logic [DATA_W-1:0]    rdat_q, rdat_d;
    logic [N_CLIENTS-1:0] ack_q, ack_d;
    logic [N_CLIENTS-1:0] err_q, err_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [7:0]           tcnt_q, tcnt_d;

    logic [N_CLIENTS-1:0] req_w;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [N_CLIENTS-1:0] pick_oh;
    logic [4:0]           cand;
    logic                 start_w;
    logic                 abort_w;
    logic                 expire_w;

    assign req_w    = cli_cyc_i & cli_stb_i;
    assign start_w  = active & pick_valid;
    // The owner is identified by its grant bit; dropping cyc means abort.
    assign abort_w  = ~|(cli_cyc_i & grant_q);
    assign expire_w = (timer_q == TMR_W'(TIMEOUT - 1));

    // First requester searching upward from the client after the last grant.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        cand       = '0;
        for (int j = 0; j < N_CLIENTS; j++) begin
            cand = 5'(ptr_q) + 5'(j) + 5'd1;
            if (cand >= 5'(N_CLIENTS)) begin
                cand = cand - 5'(N_CLIENTS);
            end
            if (!pick_valid && req_w[cand[IDX_W-1:0]]) begin
                pick_valid                = 1'b1;
                pick_idx                  = cand[IDX_W-1:0];
                pick_oh[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                end else if (rambus_wb_ack_i || expire_w) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ack_d   = '0;
        err_d   = '0;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cli_we_i[pick_idx];
                    sel_d   = cli_sel_i[pick_idx*SEL_W +: SEL_W];
                    adr_d   = cli_adr_i[pick_idx*ADDR_W +: ADDR_W];
                    wdat_d  = cli_dat_i[pick_idx*DATA_W +: DATA_W];
                    grant_d = pick_oh;
                    ptr_d   = pick_idx;
                    timer_d = '0;
                end
            end
            S_BUS: begin
                if (abort_w) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    grant_d = '0;
                end else if (rambus_wb_ack_i) begin
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    rdat_d = rambus_wb_dat_i;
                    ack_d  = grant_q;
                end else if (expire_w) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    err_d = grant_q;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                grant_d = '0;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            grant_q <= '0;
            ptr_q   <= IDX_W'(N_CLIENTS - 1);
            timer_q <= '0;
            tcnt_q  <= '0;
        end else begin
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = wb_rst_i;
    assign rambus_wb_cyc_o = cyc_q;
    assign rambus_wb_stb_o = stb_q;
    assign rambus_wb_we_o  = we_q;
    assign rambus_wb_sel_o = sel_q;
    assign rambus_wb_adr_o = adr_q;
    assign rambus_wb_dat_o = wdat_q;
    assign cli_ack_o       = ack_q;
    assign cli_err_o       = err_q;
    assign cli_dat_o       = rdat_q;
    assign grant_o         = grant_q;
    assign timeout_cnt_o   = tcnt_q;

endmodule

// File: tb/tb_rambus_wb_arbiter.sv
// Bench for rambus_wb_arbiter: grant table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_rambus_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            active;
    logic [N-1:0]    cyc, stb, we;
    logic [N*SW-1:0] sel;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] dat;
    logic [N-1:0]    ack_o, err_o, grant_o;
    logic [DW-1:0]   cdat_o;
    logic            clk_o, rst_o, rcyc, rstb, rwe;
    logic [SW-1:0]   rsel;
    logic [AW-1:0]   radr;
    logic [DW-1:0]   rwdat;
    logic            rack;
    logic [DW-1:0]   rrdat;
    logic [7:0]      tcnt;

    always #5 clk = ~clk;

    rambus_wb_arbiter #(
        .N_CLIENTS(N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT(TO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .active(active),
        .cli_cyc_i(cyc),
        .cli_stb_i(stb),
        .cli_we_i(we),
        .cli_sel_i(sel),
        .cli_adr_i(adr),
        .cli_dat_i(dat),
        .cli_ack_o(ack_o),
        .cli_err_o(err_o),
        .cli_dat_o(cdat_o),
        .rambus_wb_clk_o(clk_o),
        .rambus_wb_rst_o(rst_o),
        .rambus_wb_cyc_o(rcyc),
        .rambus_wb_stb_o(rstb),
        .rambus_wb_we_o(rwe),
        .rambus_wb_sel_o(rsel),
        .rambus_wb_adr_o(radr),
        .rambus_wb_dat_o(rwdat),
        .rambus_wb_ack_i(rack),
        .rambus_wb_dat_i(rrdat),
        .grant_o(grant_o),
        .timeout_cnt_o(tcnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // RAM responder
    logic [DW-1:0] mem [256];
    int ram_on, ram_delay, ram_cnt;

    task automatic ram_step();
        if (ram_on != 0) begin
            if (rack) begin
                rack    = 1'b0;
                ram_cnt = 0;
            end else if (rcyc && rstb) begin
                if (ram_cnt >= ram_delay) begin
                    rack  = 1'b1;
                    rrdat = mem[radr];
                    if (rwe) mem[radr] = rwdat;
                end else begin
                    ram_cnt++;
                end
            end else begin
                ram_cnt = 0;
            end
        end
    endtask

    // Reference model: one pending transaction, phase 0 idle / 1 bus / 2 done
    int            m_phase, m_owner, m_ptr, m_wait, m_tcnt;
    logic [N-1:0]  m_grant, m_ack, m_err;
    logic          m_cyc, m_we;
    logic [SW-1:0] m_sel;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wdat, m_rdata;

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_ptr = N - 1; m_grant = '0; m_cyc = 1'b0;
            m_ack = '0; m_err = '0; m_rdata = '0; m_tcnt = 0;
        end else if (m_phase == 2) begin
            m_ack = '0; m_err = '0; m_grant = '0; m_phase = 0;
        end else if (m_phase == 1) begin
            if (!cyc[m_owner]) begin
                m_phase = 0; m_cyc = 1'b0; m_grant = '0;
            end else if (rack) begin
                m_rdata = rrdat; m_cyc = 1'b0; m_ack = m_grant; m_phase = 2;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_cyc = 1'b0; m_err = m_grant; m_phase = 2;
                    if (m_tcnt < 255) m_tcnt++;
                end
            end
        end else if (active) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (m_phase == 0 && cyc[k] && stb[k]) begin
                    m_phase = 1; m_owner = k; m_ptr = k; m_wait = 0;
                    m_cyc = 1'b1; m_grant = N'(1 << k);
                    m_we = we[k]; m_sel = sel[k*SW +: SW];
                    m_adr = adr[k*AW +: AW]; m_wdat = dat[k*DW +: DW];
                end
            end
        end
    endtask

    task automatic model_compare();
        check("m_grant", grant_o, m_grant);
        check("m_bus", {rcyc, rstb}, {m_cyc, m_cyc});
        check("m_ack", ack_o, m_ack);
        check("m_err", err_o, m_err);
        check("m_rdata", cdat_o, m_rdata);
        check("m_tcnt", tcnt, 64'(m_tcnt));
        check("m_pass", {clk_o, rst_o}, {clk, rst});
        if (m_cyc) begin
            check("m_payload", {rwe, rsel, radr, rwdat},
                  {m_we, m_sel, m_adr, m_wdat});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        ram_step();
        model_compare();
    endtask

    task automatic set_req(input int k, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
        sel[k*SW +: SW] = s; adr[k*AW +: AW] = a; dat[k*DW +: DW] = d;
    endtask

    task automatic clr_req(input int k);
        cyc[k] = 1'b0; stb[k] = 1'b0;
    endtask

    task automatic clr_all();
        for (int k = 0; k < N; k++) clr_req(k);
    endtask

    task automatic ram_enable(input int d);
        ram_on = 1; ram_delay = d; ram_cnt = 0; rack = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  exp_grant;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t tv [8];
    int   cst [N];

    initial begin
        int n, acks, cyc_cnt, stalls, ng;
        logic [N-1:0]  prev_grant;
        logic [N-1:0]  rr_order [4];
        logic [DW-1:0] rr_wdat [4];
        logic [DW-1:0] old;

        for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i), 16'hBEEF ^ 16'(i)};
        mem[8'h12] = 32'hCAFEF00D;

        tv[0] = '{req: 3'b001, exp_grant: 3'b001, exp_rdata: 32'hA540BEAF};
        tv[1] = '{req: 3'b111, exp_grant: 3'b010, exp_rdata: 32'hA541BEAE};
        tv[2] = '{req: 3'b111, exp_grant: 3'b100, exp_rdata: 32'hA542BEAD};
        tv[3] = '{req: 3'b101, exp_grant: 3'b001, exp_rdata: 32'hA540BEAF};
        tv[4] = '{req: 3'b101, exp_grant: 3'b100, exp_rdata: 32'hA542BEAD};
        tv[5] = '{req: 3'b110, exp_grant: 3'b010, exp_rdata: 32'hA541BEAE};
        tv[6] = '{req: 3'b011, exp_grant: 3'b001, exp_rdata: 32'hA540BEAF};
        tv[7] = '{req: 3'b100, exp_grant: 3'b100, exp_rdata: 32'hA542BEAD};

        rst = 1'b1; active = 1'b0;
        cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0;
        rack = 1'b0; rrdat = '0; ram_on = 0; ram_delay = 0; ram_cnt = 0;
        m_phase = 0; m_ptr = N - 1; m_cyc = 1'b0; m_grant = '0;
        m_ack = '0; m_err = '0; m_rdata = '0; m_tcnt = 0; m_owner = 0;
        m_wait = 0; m_we = 1'b0; m_sel = '0; m_adr = '0; m_wdat = '0;

        tick();
        tick();
        check("rst_grant", grant_o, 0);
        check("rst_bus", {rcyc, rstb, rwe, rsel, radr}, 0);
        check("rst_wdat", rwdat, 0);
        check("rst_ackerr", {ack_o, err_o}, 0);
        check("rst_cdat", cdat_o, 0);
        check("rst_tcnt", tcnt, 0);
        check("rst_rst_o", rst_o, 1);
        rst = 1'b0;
        active = 1'b1;
        ram_enable(1);

        // Grant order table
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < N; k++) begin
                if (tv[v].req[k]) set_req(k, 1'b0, 8'(8'h40 + k), '0, 4'hF);
            end
            n = 0;
            while (grant_o == 0 && n < 20) begin tick(); n++; end
            check("tbl_grant", grant_o, tv[v].exp_grant);
            n = 0;
            while (ack_o == 0 && n < 20) begin tick(); n++; end
            check("tbl_ack", ack_o, tv[v].exp_grant);
            check("tbl_rdata", cdat_o, tv[v].exp_rdata);
            clr_all();
            tick();
            check("tbl_idle", grant_o, 0);
        end

        // Single read
        ram_enable(2);
        set_req(0, 1'b0, 8'h12, '0, 4'hF);
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rcyc) begin
                check("rd_adr", radr, 8'h12);
                check("rd_we", rwe, 0);
            end
            if (ack_o != 0) begin
                acks++;
                check("rd_ack", ack_o, 3'b001);
                check("rd_data", cdat_o, 32'hCAFEF00D);
                clr_req(0);
            end
        end
        check("rd_ack_count", acks, 1);
        check("rd_grant_idle", grant_o, 0);
        check("rd_data_hold", cdat_o, 32'hCAFEF00D);

        // Round robin between two continuous writers
        rst = 1'b1; tick(); rst = 1'b0;
        ram_enable(1);
        rr_order[0] = 3'b001; rr_order[1] = 3'b010;
        rr_order[2] = 3'b001; rr_order[3] = 3'b010;
        rr_wdat[0] = 32'h0000AAA0; rr_wdat[1] = 32'h0000BBB1;
        rr_wdat[2] = 32'h0000AAA0; rr_wdat[3] = 32'h0000BBB1;
        set_req(0, 1'b1, 8'h01, 32'h0000AAA0, 4'hF);
        set_req(1, 1'b1, 8'h02, 32'h0000BBB1, 4'hF);
        ng = 0; n = 0; prev_grant = '0;
        while (ng < 4 && n < 80) begin
            tick(); n++;
            if (grant_o != 0 && prev_grant == 0) begin
                check("rr_order", grant_o, rr_order[ng]);
                check("rr_wdat", rwdat, rr_wdat[ng]);
                ng++;
            end
            prev_grant = grant_o;
            for (int k = 0; k < 2; k++) stb[k] = !ack_o[k];
        end
        check("rr_count", ng, 4);
        clr_all();
        tick(); tick(); tick();

        // Timeout
        ram_on = 0; rack = 1'b0;
        set_req(0, 1'b0, 8'h20, '0, 4'hF);
        cyc_cnt = 0; acks = 0; n = 0;
        while (err_o == 0 && n < 20) begin
            tick(); n++;
            if (rcyc) cyc_cnt++;
            if (ack_o != 0) acks++;
        end
        check("to_err", err_o, 3'b001);
        clr_req(0);
        check("to_cyc_cycles", cyc_cnt, 4);
        check("to_no_ack", acks, 0);
        check("to_tcnt1", tcnt, 1);
        tick();
        check("to_err_pulse", err_o, 0);
        stalls = 0;
        for (int t = 0; t < 299; t++) begin
            set_req(0, 1'b0, 8'h20, '0, 4'hF);
            n = 0;
            while (err_o == 0 && n < 20) begin tick(); n++; end
            if (n >= 20) stalls++;
            clr_req(0);
            tick();
        end
        check("to_stalls", stalls, 0);
        check("to_saturate", tcnt, 255);

        // Abort colliding with RAM ack
        set_req(1, 1'b0, 8'h30, '0, 4'hF);
        n = 0;
        while (grant_o == 0 && n < 20) begin tick(); n++; end
        check("ab_grant", grant_o, 3'b010);
        tick();
        old = cdat_o;
        clr_req(1);
        rack = 1'b1; rrdat = 32'hDEADBEEF;
        tick();
        rack = 1'b0;
        check("ab_cyc", {rcyc, rstb}, 0);
        check("ab_grant0", grant_o, 0);
        check("ab_noresp", {ack_o, err_o}, 0);
        tick();
        check("ab_noresp2", {ack_o, err_o}, 0);
        check("ab_data_hold", cdat_o, old);

        // Active gating
        active = 1'b0;
        set_req(0, 1'b0, 8'h05, '0, 4'hF);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("gate_quiet", {rcyc, grant_o}, 0);
        end
        active = 1'b1;
        tick();
        check("gate_grant", grant_o, 3'b001);
        ram_enable(2);
        active = 1'b0;
        n = 0;
        while (ack_o == 0 && n < 20) begin tick(); n++; end
        check("gate_ack", ack_o, 3'b001);
        check("gate_data", cdat_o, 32'hA505BEEA);
        clr_req(0);
        tick();
        active = 1'b1;

        // Reset in BUS
        ram_on = 0; rack = 1'b0;
        set_req(2, 1'b1, 8'h33, 32'h12345678, 4'h3);
        n = 0;
        while (grant_o == 0 && n < 20) begin tick(); n++; end
        check("rs_grant", grant_o, 3'b100);
        tick();
        rst = 1'b1;
        clr_req(2);
        set_req(0, 1'b0, 8'h07, '0, 4'hF);
        set_req(1, 1'b0, 8'h08, '0, 4'hF);
        tick();
        check("rs_bus", {rcyc, rstb, rwe, rsel, radr}, 0);
        check("rs_wdat", rwdat, 0);
        check("rs_cli", {ack_o, err_o, grant_o}, 0);
        check("rs_cdat", cdat_o, 0);
        check("rs_tcnt", tcnt, 0);
        check("rs_rst_o", rst_o, 1);
        rst = 1'b0;
        tick();
        check("rs_first", grant_o, 3'b001);
        ram_enable(0);
        acks = 0; n = 0;
        while (acks < 2 && n < 40) begin
            tick(); n++;
            for (int k = 0; k < 2; k++) begin
                if (ack_o[k]) begin acks++; clr_req(k); end
            end
        end
        check("rs_served", acks, 2);
        tick();

        // Randomized traffic against the model
        ram_enable(1);
        for (int k = 0; k < N; k++) cst[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 999) < 3) rst = 1'b1;
            if (!active) active = ($urandom_range(0, 99) < 20);
            else if ($urandom_range(0, 99) < 3) active = 1'b0;
            if (!rcyc) ram_delay = $urandom_range(0, 5);
            for (int k = 0; k < N; k++) begin
                if (cst[k] != 0) begin
                    if (ack_o[k] || err_o[k]) begin
                        clr_req(k); cst[k] = 0;
                    end else if ($urandom_range(0, 99) < 2) begin
                        clr_req(k); cst[k] = 0;
                    end
                end else if ($urandom_range(0, 99) < 30) begin
                    set_req(k, 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
                    cst[k] = 1;
                end
            end
        end
        clr_all();
        rst = 1'b0;
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
